// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : shared selection-mode encodings and default datapath width
// Rev 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;
  localparam logic MODE_RR   = 1'b0;
  localparam logic MODE_PRIO = 1'b1;
  localparam int   DATA_W    = 32;
endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// rr_arbiter : one-hot grant, round-robin from ptr or fixed lowest-index priority
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
  import cpu_pkg::*;
#(
  parameter int N    = 4,
  parameter int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  input  logic            mode,
  output logic [N-1:0]    grant
);

  logic [IDXW-1:0] w_base;
  logic [2*N-1:0]  w_req_dbl;
  logic [N-1:0]    w_rot;
  logic [N-1:0]    w_rot_gnt;
  logic [2*N-1:0]  w_gnt_dbl;

  // Fixed priority is round-robin anchored at channel 0.
  assign w_base    = (mode == MODE_PRIO) ? '0 : ptr;

  // Rotate right by the base so the scan start lands at bit 0, isolate the
  // lowest set bit, then rotate back; the double width provides the wrap.
  assign w_req_dbl = {req, req} >> w_base;
  assign w_rot     = w_req_dbl[N-1:0];
  assign w_rot_gnt = w_rot & (~w_rot + {{(N-1){1'b0}}, 1'b1});
  assign w_gnt_dbl = {{N{1'b0}}, w_rot_gnt} << w_base;
  assign grant     = w_gnt_dbl[N-1:0] | w_gnt_dbl[2*N-1:N];

endmodule

`default_nettype wire

// File: rtl/arb_mux_n.sv
// ============================================================================
// arb_mux_n : N-channel arbitrated selector with registered valid/ready output
// Rev 1.0
// ============================================================================
`default_nettype none

module arb_mux_n
  import cpu_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int N     = 4,
  parameter int IDXW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic               force_en,
  input  logic [IDXW-1:0]    force_sel,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [N*WIDTH-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [IDXW-1:0]    out_sel
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [IDXW-1:0]  r_out_sel;
  logic [IDXW-1:0]  r_ptr;

  logic [N-1:0]     w_force_oh;
  logic [N-1:0]     w_elig;
  logic [N-1:0]     w_grant;
  logic [N-1:0]     w_ready;
  logic             w_can_accept;
  logic             w_xfer;
  logic [IDXW-1:0]  w_idx;
  logic [WIDTH-1:0] w_sel_data;
  logic [IDXW-1:0]  w_ptr_next;

  // An out-of-range force_sel matches no channel, leaving nothing eligible.
  always_comb begin
    w_force_oh = '0;
    for (int i = 0; i < N; i++) begin
      if (force_sel == IDXW'(i)) w_force_oh[i] = 1'b1;
    end
  end

  assign w_elig = force_en ? (in_valid & w_force_oh) : in_valid;

  rr_arbiter #(
    .N    (N),
    .IDXW (IDXW)
  ) u_arb (
    .req   (w_elig),
    .ptr   (r_ptr),
    .mode  (mode),
    .grant (w_grant)
  );

  assign w_can_accept = ~r_out_valid | out_ready;
  assign w_ready      = w_grant & {N{w_can_accept & ~reset}};
  assign w_xfer       = |(in_valid & w_ready);

  always_comb begin
    w_idx      = '0;
    w_sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_ready[i]) begin
        w_idx      = IDXW'(i);
        w_sel_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_ptr_next = (w_idx == IDXW'(N-1)) ? '0 : (w_idx + IDXW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_ptr       <= '0;
    end else begin
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sel_data;
        r_out_sel   <= w_idx;
        if (mode == MODE_RR && !force_en) r_ptr <= w_ptr_next;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = w_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule

`default_nettype wire

// File: tb/tb_arb_mux_n.sv
// ============================================================================
// tb_arb_mux_n : directed and randomized checks of arb_mux_n (N=4/32b, N=3/8b)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_arb_mux_n;

  logic         clk = 1'b0;
  logic         reset;
  logic         mode, force_en, out_ready, out_valid;
  logic [1:0]   force_sel, out_sel;
  logic [3:0]   in_valid, in_ready;
  logic [127:0] in_data;
  logic [31:0]  out_data;

  logic         mode3, fen3, or3, ov3;
  logic [1:0]   fsel3, os3;
  logic [2:0]   iv3, ir3;
  logic [23:0]  id3;
  logic [7:0]   od3;

  int errors = 0;
  int checks = 0;

  int          m_ptr [2];
  bit          m_ov  [2];
  logic [31:0] m_od  [2];
  int          m_os  [2];
  logic [3:0]  acc0;
  logic [2:0]  acc1;

  always #5 clk = ~clk;

  arb_mux_n #(.WIDTH(32), .N(4)) dut4 (
    .clk(clk), .reset(reset), .mode(mode), .force_en(force_en),
    .force_sel(force_sel), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sel(out_sel)
  );

  arb_mux_n #(.WIDTH(8), .N(3)) dut3 (
    .clk(clk), .reset(reset), .mode(mode3), .force_en(fen3),
    .force_sel(fsel3), .in_valid(iv3), .in_ready(ir3),
    .in_data(id3), .out_valid(ov3), .out_ready(or3),
    .out_data(od3), .out_sel(os3)
  );

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Channel the rules pick, or -1 when nothing is eligible.
  function automatic int exp_grant(int n, int ptr, bit md, bit fen, int fsel, int valid);
    if (fen) begin
      if (fsel < n && ((valid >> fsel) & 1) == 1) return fsel;
      return -1;
    end
    for (int k = 0; k < n; k++) begin
      int c;
      c = md ? k : (ptr + k) % n;
      if (((valid >> c) & 1) == 1) return c;
    end
    return -1;
  endfunction

  // One cycle: compare both DUTs against the model, clock, advance the model.
  task automatic tick();
    int g0, g1;
    logic [3:0] er0;
    logic [2:0] er1;
    #1;
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        m_ptr[k] = 0; m_ov[k] = 0; m_od[k] = '0; m_os[k] = 0;
      end
    end
    g0  = exp_grant(4, m_ptr[0], mode, force_en, int'(force_sel), int'(in_valid));
    g1  = exp_grant(3, m_ptr[1], mode3, fen3, int'(fsel3), int'(iv3));
    er0 = (!reset && (!m_ov[0] || out_ready) && g0 >= 0) ? 4'(1 << g0) : 4'b0;
    er1 = (!reset && (!m_ov[1] || or3) && g1 >= 0) ? 3'(1 << g1) : 3'b0;
    acc0 = er0;
    acc1 = er1;
    chk("n4_in_ready",  in_ready,  er0);
    chk("n4_out_valid", out_valid, m_ov[0]);
    chk("n4_out_data",  out_data,  m_od[0]);
    chk("n4_out_sel",   out_sel,   m_os[0]);
    chk("n3_in_ready",  ir3,       er1);
    chk("n3_out_valid", ov3,       m_ov[1]);
    chk("n3_out_data",  od3,       m_od[1][7:0]);
    chk("n3_out_sel",   os3,       m_os[1]);
    @(posedge clk);
    if (!reset) begin
      if (er0 != 0) begin
        m_od[0] = in_data[g0*32 +: 32];
        m_os[0] = g0;
        m_ov[0] = 1;
        if (!mode && !force_en) m_ptr[0] = (g0 + 1) % 4;
      end else if (out_ready) m_ov[0] = 0;
      if (er1 != 0) begin
        m_od[1] = {24'b0, id3[g1*8 +: 8]};
        m_os[1] = g1;
        m_ov[1] = 1;
        if (!mode3 && !fen3) m_ptr[1] = (g1 + 1) % 3;
      end else if (or3) m_ov[1] = 0;
    end
    #1;
  endtask

  initial begin
    reset = 1'b1; mode = 1'b0; force_en = 1'b0; force_sel = 2'd0; out_ready = 1'b1;
    in_valid = 4'b1111;
    for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'h100 + i;
    mode3 = 1'b0; fen3 = 1'b0; fsel3 = 2'd0; iv3 = 3'b000; or3 = 1'b1; id3 = 24'h332211;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_data", out_data, 0);
    tick();
    tick();

    // Round-robin order from reset
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      logic [1:0] exp_seq;
      exp_seq = 2'(k % 4);
      tick();
      chk("rr_seq_valid", out_valid, 1);
      chk("rr_seq_sel", out_sel, exp_seq);
    end

    // Fixed priority; ptr (now 1) must survive it
    mode = 1'b1; in_valid = 4'b1010;
    in_data[32 +: 32] = 32'h11; in_data[96 +: 32] = 32'h33;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("prio_ready", in_ready, 4'b0010);
      tick();
      chk("prio_data", out_data, 32'h11);
      chk("prio_sel", out_sel, 1);
    end
    mode = 1'b0; in_valid = 4'b1101;
    tick();
    chk("ptr_kept_sel", out_sel, 2);

    // Back-pressure with ch2 = DEADBEEF held
    force_en = 1'b1; force_sel = 2'd2; in_valid = 4'b0100;
    in_data[64 +: 32] = 32'hDEADBEEF;
    tick();
    chk("bp_load", out_data, 32'hDEADBEEF);
    force_en = 1'b0; out_ready = 1'b0; in_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_ready", in_ready, 0);
      chk("bp_hold", out_data, 32'hDEADBEEF);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_refill_valid", out_valid, 1);
    chk("bp_refill_sel", out_sel, 3);
    chk("bp_refill_data", out_data, 32'h33);

    // Force select
    force_en = 1'b1; force_sel = 2'd2; in_valid = 4'b0101;
    #1;
    chk("force_ready", in_ready, 4'b0100);
    tick();
    in_valid = 4'b0001;
    #1;
    chk("force_none", in_ready, 0);
    tick();
    chk("force_drain", out_valid, 0);

    // Wrap 3 -> 0, then asynchronous reset between edges
    force_en = 1'b0; in_valid = 4'b0100;
    tick();
    in_valid = 4'b1001;
    tick();
    chk("wrap_sel3", out_sel, 3);
    tick();
    chk("wrap_sel0", out_sel, 0);
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_ready", in_ready, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("after_rst_sel", out_sel, 0);

    // N=3 sweep: out-of-range force, then round-robin 0,1,2,0
    iv3 = 3'b111; fen3 = 1'b1; fsel3 = 2'd3;
    #1;
    chk("n3_force_oob", ir3, 0);
    tick();
    fen3 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] exp3;
      exp3 = 2'(k % 3);
      tick();
      chk("n3_rr_sel", os3, exp3);
    end

    // Randomized traffic; requests stay up with stable data until accepted
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (!in_valid[i] || acc0[i]) begin
          in_valid[i] = 1'($urandom_range(0, 1));
          in_data[i*32 +: 32] = $urandom;
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (!iv3[i] || acc1[i]) begin
          iv3[i] = 1'($urandom_range(0, 1));
          id3[i*8 +: 8] = 8'($urandom);
        end
      end
      mode      = 1'($urandom_range(0, 1));
      force_en  = ($urandom_range(0, 3) == 0);
      force_sel = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      mode3     = 1'($urandom_range(0, 1));
      fen3      = ($urandom_range(0, 3) == 0);
      fsel3     = 2'($urandom_range(0, 3));
      or3       = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
